washer_ctrl_v2: RTL and testbench
=================================

Name: washer_ctrl_v2

Overview:
- Parametrised washing-machine sequencer, successor to the single-pass controller.
- Adds per-mode wash, rinse-count and spin lengths, multiple rinse passes, and sensor-terminated fill/drain with timeout faults.
- Adds pause/resume, abort-with-drain, a door-lock output and a cycle-complete pulse.
- Sits between the front-panel input logic and the valve/motor driver block.

Parameters:
TW, 8, width of phase timer and all duration parameters
WASH_L / WASH_N / WASH_H, 10 / 20 / 30, wash cycles for light / normal / heavy
SPIN_L / SPIN_N / SPIN_H, 5 / 10 / 15, spin cycles per mode
RINSES_L / RINSES_N / RINSES_H, 1 / 2 / 3, rinse passes per mode (legal range 1..15)
RINSE_T, 5, cycles per rinse pass
FILL_TO, 20, fill timeout in cycles
DRAIN_TO, 20, drain timeout in cycles

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin cycle; sampled only in IDLE
mode  in  2  00 light, 01 normal, 10 heavy, 11 illegal; latched on accepted start
pause  in  1  level; freezes the cycle while high
abort  in  1  pulse/level; terminate the cycle via drain
level_full  in  1  water-level sensor: drum full
level_empty  in  1  water-level sensor: drum empty
state  out  4  current state code
fill, wash, rinse, spin, drain  out  1 each  actuator enables
door_lock  out  1  door locked
done  out  1  one-cycle pulse on normal completion
fault  out  1  sticky fault indication
rinse_cnt  out  4  completed rinse passes in the current cycle

Behaviour:
- State codes: IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4, DRAIN=5, DONE=6, PAUSE=7, FAULT=8.
- Reset (async) state: IDLE. All outputs 0, timer 0, rinse_cnt 0, abort flag 0, wash_done flag 0.
- Outputs are decoded from the state register; state port = state register.
- fill=1 only in FILL; wash only in WASH; rinse only in RINSE; spin only in SPIN; drain in DRAIN and in FAULT.
- door_lock=1 in FILL, WASH, RINSE, SPIN, DRAIN and PAUSE.
- done=1 only in DONE. fault=1 only in FAULT.
- Timer: cleared on every state entry, except resume from PAUSE, where it keeps its value. Increments every cycle in FILL, WASH, RINSE, SPIN and DRAIN. Held in PAUSE.
- Timed states (WASH/RINSE/SPIN) with duration T: exit when timer==T-1, so the state lasts exactly T cycles.
- IDLE: on start with mode!=11:
  - latch the mode's parameters;
  - clear rinse_cnt, wash_done and the abort flag;
  - go to FILL next cycle.
  - start with mode==11 is ignored; remain in IDLE.
- FILL, priority order:
  - abort -> DRAIN with abort flag set;
  - level_full -> WASH if wash_done==0, else RINSE;
  - timer==FILL_TO-1 -> FAULT;
  - pause -> PAUSE.
- WASH: exit to DRAIN and set wash_done.
- RINSE: exit to DRAIN and increment rinse_cnt.
- SPIN: exit to DONE.
- DRAIN, on level_empty:
  - abort flag set -> IDLE (no done pulse);
  - else rinse_cnt < rinses -> FILL;
  - else -> SPIN.
  - If timer==DRAIN_TO-1 without level_empty -> FAULT.
  - abort in DRAIN sets the abort flag. pause is ignored in DRAIN.
- Abort/pause priority in WASH, RINSE and SPIN: abort -> DRAIN with abort flag; otherwise pause -> PAUSE; otherwise the timed exit.
- PAUSE:
  - Return state is stored on entry.
  - abort -> DRAIN with abort flag set.
  - pause low -> return state; the timer resumes from its held value.
  - Actuators are all 0; door stays locked.
- DONE: one cycle, then IDLE.
- FAULT: absorbing; exits only on reset.
- Reset mid-cycle: immediate return to IDLE with all actuators off. No drain is performed.
- Sensors are assumed synchronous to clk. Both sensors high at once is treated per the state's own sensor only.

Test Plan:
- Light mode, level_full asserted 3 cycles after FILL entry, level_empty 2 cycles after each DRAIN entry -> sequence is:
  - FILL 3, WASH 10, DRAIN 2, FILL 3, RINSE 5, DRAIN 2, SPIN 5, DONE 1 cycle;
  - rinse_cnt ends at 1; done pulses once.
- Heavy mode, same sensor timing -> three rinse passes; rinse_cnt steps 1, 2, 3; SPIN lasts 15 cycles; total cycle length checked exactly.
- pause high for 7 cycles at WASH timer=4 -> PAUSE for 7 cycles, all actuators 0, door_lock=1; WASH then completes after 6 more cycles (10 WASH cycles total).
- abort during RINSE pass 1 -> DRAIN next cycle; after level_empty -> IDLE; done never asserted; door_lock drops.
- level_full never asserted -> FAULT after exactly 20 FILL cycles; drain=1 and fault=1 held until reset; start ignored while in FAULT.
- start with mode=11 -> stays IDLE. Async reset asserted mid-SPIN -> all outputs 0 immediately; state=0.

Source files
------------

// File: rtl/washer_ctrl_v2_if.sv
// rtl/washer_ctrl_v2_if.sv - panel, sensor and actuator signals of the washer sequencer
interface washer_ctrl_v2_if;
    logic       start;
    logic [1:0] mode;
    logic       pause;
    logic       abort;
    logic       level_full;
    logic       level_empty;
    logic [3:0] state;
    logic       fill;
    logic       wash;
    logic       rinse;
    logic       spin;
    logic       drain;
    logic       door_lock;
    logic       done;
    logic       fault;
    logic [3:0] rinse_cnt;

    modport master (
        output start, mode, pause, abort, level_full, level_empty,
        input  state, fill, wash, rinse, spin, drain, door_lock, done, fault, rinse_cnt
    );

    modport slave (
        input  start, mode, pause, abort, level_full, level_empty,
        output state, fill, wash, rinse, spin, drain, door_lock, done, fault, rinse_cnt
    );
endinterface

// File: rtl/washer_ctrl_v2.sv
// rtl/washer_ctrl_v2.sv - multi-rinse washer sequencer with pause, abort-drain and fill/drain timeouts
module washer_ctrl_v2 #(
    parameter int            TW        = 8,
    parameter logic [TW-1:0] WASH_L    = TW'(10),
    parameter logic [TW-1:0] WASH_N    = TW'(20),
    parameter logic [TW-1:0] WASH_H    = TW'(30),
    parameter logic [TW-1:0] SPIN_L    = TW'(5),
    parameter logic [TW-1:0] SPIN_N    = TW'(10),
    parameter logic [TW-1:0] SPIN_H    = TW'(15),
    parameter logic [3:0]    RINSES_L  = 4'd1,
    parameter logic [3:0]    RINSES_N  = 4'd2,
    parameter logic [3:0]    RINSES_H  = 4'd3,
    parameter logic [TW-1:0] RINSE_T   = TW'(5),
    parameter logic [TW-1:0] FILL_TO   = TW'(20),
    parameter logic [TW-1:0] DRAIN_TO  = TW'(20)
) (
    input  logic             clk,
    input  logic             reset,
    washer_ctrl_v2_if.slave  bus
);
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_FILL  = 4'd1,
        S_WASH  = 4'd2,
        S_RINSE = 4'd3,
        S_SPIN  = 4'd4,
        S_DRAIN = 4'd5,
        S_DONE  = 4'd6,
        S_PAUSE = 4'd7,
        S_FAULT = 4'd8
    } state_t;

    localparam logic [TW-1:0] FILL_LAST  = FILL_TO - TW'(1);
    localparam logic [TW-1:0] DRAIN_LAST = DRAIN_TO - TW'(1);

    state_t        state_q, state_d, ret_q;
    logic [TW-1:0] timer_q;
    logic [3:0]    rinse_cnt_q;
    logic          abort_q, wash_done_q;
    logic [TW-1:0] wash_len_q, spin_len_q;
    logic [3:0]    rinses_q;
    logic [TW-1:0] cur_len;
    logic          timed_end, counting;
    logic          start_ok, set_abort, set_wash_done, inc_rinse;

    always_comb begin
        case (state_q)
            S_WASH:  cur_len = wash_len_q;
            S_SPIN:  cur_len = spin_len_q;
            default: cur_len = RINSE_T;
        endcase
    end

    // >= rather than == so a pause taken on the final cycle still exits on resume
    assign timed_end = timer_q >= (cur_len - TW'(1));
    assign counting  = state_q inside {S_FILL, S_WASH, S_RINSE, S_SPIN, S_DRAIN};

    always_comb begin
        state_d       = state_q;
        start_ok      = 1'b0;
        set_abort     = 1'b0;
        set_wash_done = 1'b0;
        inc_rinse     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && bus.mode != 2'b11) begin
                    start_ok = 1'b1;
                    state_d  = S_FILL;
                end
            end
            S_FILL: begin
                if (bus.abort) begin
                    set_abort = 1'b1;
                    state_d   = S_DRAIN;
                end else if (bus.level_full) begin
                    state_d = wash_done_q ? S_RINSE : S_WASH;
                end else if (timer_q >= FILL_LAST) begin
                    state_d = S_FAULT;
                end else if (bus.pause) begin
                    state_d = S_PAUSE;
                end
            end
            S_WASH, S_RINSE, S_SPIN: begin
                if (bus.abort) begin
                    set_abort = 1'b1;
                    state_d   = S_DRAIN;
                end else if (bus.pause) begin
                    state_d = S_PAUSE;
                end else if (timed_end) begin
                    if (state_q == S_WASH) begin
                        set_wash_done = 1'b1;
                        state_d       = S_DRAIN;
                    end else if (state_q == S_RINSE) begin
                        inc_rinse = 1'b1;
                        state_d   = S_DRAIN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DRAIN: begin
                set_abort = bus.abort;
                if (bus.level_empty) begin
                    if (abort_q || bus.abort) state_d = S_IDLE;
                    else if (rinse_cnt_q < rinses_q) state_d = S_FILL;
                    else state_d = S_SPIN;
                end else if (timer_q >= DRAIN_LAST) begin
                    state_d = S_FAULT;
                end
            end
            S_PAUSE: begin
                if (bus.abort) begin
                    set_abort = 1'b1;
                    state_d   = S_DRAIN;
                end else if (!bus.pause) begin
                    state_d = ret_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ret_q       <= S_IDLE;
            timer_q     <= '0;
            rinse_cnt_q <= '0;
            abort_q     <= 1'b0;
            wash_done_q <= 1'b0;
            wash_len_q  <= '0;
            spin_len_q  <= '0;
            rinses_q    <= '0;
        end else begin
            state_q <= state_d;
            // the cycle that enters PAUSE still counts as a working cycle
            if (state_d == S_PAUSE && state_q != S_PAUSE) begin
                ret_q   <= state_q;
                timer_q <= timer_q + TW'(1);
            end else if (state_d != state_q && !(state_q == S_PAUSE && state_d == ret_q)) begin
                timer_q <= '0;
            end else if (counting) begin
                timer_q <= timer_q + TW'(1);
            end
            if (start_ok) begin
                rinse_cnt_q <= '0;
                wash_done_q <= 1'b0;
                abort_q     <= 1'b0;
                case (bus.mode)
                    2'b00: begin wash_len_q <= WASH_L; spin_len_q <= SPIN_L; rinses_q <= RINSES_L; end
                    2'b01: begin wash_len_q <= WASH_N; spin_len_q <= SPIN_N; rinses_q <= RINSES_N; end
                    default: begin wash_len_q <= WASH_H; spin_len_q <= SPIN_H; rinses_q <= RINSES_H; end
                endcase
            end
            if (set_abort)     abort_q     <= 1'b1;
            if (set_wash_done) wash_done_q <= 1'b1;
            if (inc_rinse)     rinse_cnt_q <= rinse_cnt_q + 4'd1;
        end
    end

    assign bus.state     = state_q;
    assign bus.fill      = (state_q == S_FILL);
    assign bus.wash      = (state_q == S_WASH);
    assign bus.rinse     = (state_q == S_RINSE);
    assign bus.spin      = (state_q == S_SPIN);
    assign bus.drain     = (state_q == S_DRAIN) || (state_q == S_FAULT);
    assign bus.door_lock = state_q inside {S_FILL, S_WASH, S_RINSE, S_SPIN, S_DRAIN, S_PAUSE};
    assign bus.done      = (state_q == S_DONE);
    assign bus.fault     = (state_q == S_FAULT);
    assign bus.rinse_cnt = rinse_cnt_q;
endmodule

// File: tb/tb_washer_ctrl_v2.sv
// tb/tb_washer_ctrl_v2.sv - randomized and directed bench for washer_ctrl_v2 against a behavioural model
module tb_washer_ctrl_v2;
    localparam int RINSE_T = 5, FILL_TO = 20, DRAIN_TO = 20;
    localparam int S_IDLE = 0, S_FILL = 1, S_WASH = 2, S_RINSE = 3, S_SPIN = 4;
    localparam int S_DRAIN = 5, S_DONE = 6, S_PAUSE = 7, S_FAULT = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    washer_ctrl_v2_if bus();
    washer_ctrl_v2 dut (.clk(clk), .reset(reset), .bus(bus));

    logic       dir_start = 1'b0, dir_pause = 1'b0, dir_abort = 1'b0;
    logic [1:0] dir_mode = 2'b00;
    logic       rand_en = 1'b0, rnd_pause = 1'b0, rnd_abort = 1'b0;
    logic       lf = 1'b0, le = 1'b0;
    int         full_delay = 3, empty_delay = 2;
    int         fill_run = 0, drain_run = 0;

    assign bus.start       = dir_start;
    assign bus.mode        = dir_mode;
    assign bus.pause       = rand_en ? rnd_pause : dir_pause;
    assign bus.abort       = rand_en ? rnd_abort : dir_abort;
    assign bus.level_full  = lf;
    assign bus.level_empty = le;

    int checks = 0, errors = 0;
    int hist[16];
    int total;

    // drum plant: sensors respond a set number of cycles into each fill/drain
    always @(negedge clk) begin
        fill_run  = bus.fill ? fill_run + 1 : 0;
        drain_run = (bus.state == 4'd5) ? drain_run + 1 : 0;
        lf = bus.fill && (fill_run >= full_delay);
        le = (bus.state == 4'd5) && (drain_run >= empty_delay);
        if (rand_en) begin
            if (rnd_pause) rnd_pause = ($urandom_range(0, 3) != 0);
            else           rnd_pause = ($urandom_range(0, 29) == 0);
            rnd_abort = ($urandom_range(0, 99) == 0);
        end else begin
            rnd_pause = 1'b0;
            rnd_abort = 1'b0;
        end
    end

    // behavioural model: remaining-cycle and waited-cycle counters per phase
    int m_st = 0, m_ret = 0, m_left = 0, m_wait = 0, m_rdone = 0;
    int m_rinses = 0, m_spin = 0, m_wash = 0;
    bit m_aborted = 1'b0, m_washed = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_st = S_IDLE; m_left = 0; m_wait = 0; m_rdone = 0;
            m_aborted = 1'b0; m_washed = 1'b0;
        end else begin
            case (m_st)
                S_IDLE: if (bus.start && bus.mode != 2'b11) begin
                    m_wash = 10 * (bus.mode + 1);
                    m_spin = 5 * (bus.mode + 1);
                    m_rinses = bus.mode + 1;
                    m_rdone = 0; m_washed = 1'b0; m_aborted = 1'b0; m_wait = 0;
                    m_st = S_FILL;
                end
                S_FILL: begin
                    if (bus.abort) begin
                        m_aborted = 1'b1; m_wait = 0; m_st = S_DRAIN;
                    end else if (bus.level_full) begin
                        m_left = m_washed ? RINSE_T : m_wash;
                        m_st = m_washed ? S_RINSE : S_WASH;
                    end else if (m_wait == FILL_TO - 1) begin
                        m_st = S_FAULT;
                    end else begin
                        m_wait++;
                        if (bus.pause) begin m_ret = S_FILL; m_st = S_PAUSE; end
                    end
                end
                S_WASH, S_RINSE, S_SPIN: begin
                    if (bus.abort) begin
                        m_aborted = 1'b1; m_wait = 0; m_st = S_DRAIN;
                    end else if (bus.pause) begin
                        m_left--; m_ret = m_st; m_st = S_PAUSE;
                    end else if (m_left <= 1) begin
                        if (m_st == S_WASH) begin m_washed = 1'b1; m_wait = 0; m_st = S_DRAIN; end
                        else if (m_st == S_RINSE) begin m_rdone++; m_wait = 0; m_st = S_DRAIN; end
                        else m_st = S_DONE;
                    end else begin
                        m_left--;
                    end
                end
                S_DRAIN: begin
                    if (bus.abort) m_aborted = 1'b1;
                    if (bus.level_empty) begin
                        if (m_aborted) m_st = S_IDLE;
                        else if (m_rdone < m_rinses) begin m_wait = 0; m_st = S_FILL; end
                        else begin m_left = m_spin; m_st = S_SPIN; end
                    end else if (m_wait == DRAIN_TO - 1) begin
                        m_st = S_FAULT;
                    end else begin
                        m_wait++;
                    end
                end
                S_PAUSE: begin
                    if (bus.abort) begin m_aborted = 1'b1; m_wait = 0; m_st = S_DRAIN; end
                    else if (!bus.pause) m_st = m_ret;
                end
                S_DONE: m_st = S_IDLE;
                default: ;
            endcase
        end
    end

    function automatic logic [15:0] outs();
        return {bus.state, bus.fill, bus.wash, bus.rinse, bus.spin, bus.drain,
                bus.door_lock, bus.done, bus.fault, bus.rinse_cnt};
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cycle_check();
        logic [15:0] e, g;
        logic door;
        door = (m_st >= S_FILL && m_st <= S_DRAIN) || m_st == S_PAUSE;
        e = {m_st[3:0], m_st == S_FILL, m_st == S_WASH, m_st == S_RINSE, m_st == S_SPIN,
             (m_st == S_DRAIN || m_st == S_FAULT), door, m_st == S_DONE, m_st == S_FAULT, m_rdone[3:0]};
        g = outs();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL cycle_outputs got %h expected %h at %0t", g, e, $time);
        end
    endtask

    task automatic do_start(input logic [1:0] md);
        @(negedge clk);
        dir_mode = md; dir_start = 1'b1;
        @(negedge clk);
        dir_start = 1'b0;
    endtask

    task automatic wait_state(input int s, input int maxc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.state != 4'(s) && n < maxc);
        if (bus.state != 4'(s)) begin
            checks++; errors++;
            $display("FAIL wait_state %0d timeout, state %0d", s, bus.state);
        end
    endtask

    // histogram of states from the current cycle until IDLE or FAULT
    task automatic run_hist(input int maxc);
        int n;
        bit fin;
        for (int i = 0; i < 16; i++) hist[i] = 0;
        hist[bus.state]++;
        total = 1; n = 0; fin = 1'b0;
        while (!fin && n < maxc) begin
            @(negedge clk);
            n++;
            if (bus.state == 4'd0 || bus.state == 4'd8) fin = 1'b1;
            else begin hist[bus.state]++; total++; end
        end
        if (!fin) begin
            checks++; errors++;
            $display("FAIL run_hist timeout, state %0d", bus.state);
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk); #2 reset = 1'b1;
        @(negedge clk); #2 reset = 1'b0;
    endtask

    initial begin
        int n, seen;
        fork
            forever begin @(negedge clk); cycle_check(); end
            begin #2000000; $display("FAIL watchdog expired"); $fatal(1); end
        join_none

        repeat (2) @(negedge clk);
        chk("reset_outputs", int'(outs()), 0);
        #2 reset = 1'b0;

        // light mode full cycle
        do_start(2'b00);
        run_hist(200);
        chk("light_total", total, 31);
        chk("light_fill", hist[S_FILL], 6);
        chk("light_wash", hist[S_WASH], 10);
        chk("light_rinse", hist[S_RINSE], 5);
        chk("light_drain", hist[S_DRAIN], 4);
        chk("light_spin", hist[S_SPIN], 5);
        chk("light_done", hist[S_DONE], 1);
        chk("light_rinse_cnt", int'(bus.rinse_cnt), 1);
        chk("model_light_rinses", m_rdone, 1);

        // heavy mode full cycle
        do_start(2'b10);
        run_hist(400);
        chk("heavy_total", total, 81);
        chk("heavy_rinse", hist[S_RINSE], 15);
        chk("heavy_spin", hist[S_SPIN], 15);
        chk("heavy_fill", hist[S_FILL], 12);
        chk("heavy_done", hist[S_DONE], 1);
        chk("heavy_rinse_cnt", int'(bus.rinse_cnt), 3);
        chk("model_heavy_rinses", m_rdone, 3);

        // pause taken so PAUSE is entered with the wash timer at 4
        do_start(2'b00);
        wait_state(S_WASH, 50);
        repeat (3) @(negedge clk);
        dir_pause = 1'b1;
        seen = 0;
        repeat (7) begin
            @(negedge clk);
            if (bus.state == 4'd7 && bus.door_lock && !bus.wash && !bus.fill && !bus.drain) seen++;
        end
        dir_pause = 1'b0;
        @(negedge clk);
        n = 0;
        while (bus.state == 4'd2 && n < 100) begin n++; @(negedge clk); end
        chk("pause_cycles", seen, 7);
        chk("wash_after_resume", n, 6);
        wait_state(S_IDLE, 200);

        // abort during the first rinse pass
        do_start(2'b00);
        wait_state(S_RINSE, 100);
        dir_abort = 1'b1;
        @(negedge clk);
        dir_abort = 1'b0;
        chk("abort_to_drain", int'(bus.state), S_DRAIN);
        seen = 0; n = 0;
        while (bus.state != 4'd0 && n < 100) begin
            @(negedge clk); n++;
            if (bus.done) seen++;
        end
        chk("abort_idle", int'(bus.state), S_IDLE);
        chk("abort_no_done", seen, 0);
        chk("abort_door", int'(bus.door_lock), 0);

        // fill timeout
        full_delay = 255;
        do_start(2'b01);
        run_hist(100);
        chk("fault_fill_cycles", hist[S_FILL], 20);
        repeat (3) @(negedge clk);
        chk("fault_held", int'({bus.drain, bus.fault, bus.state}), 'h38);
        do_start(2'b00);
        @(negedge clk);
        chk("fault_ignores_start", int'(bus.state), S_FAULT);
        reset_pulse();
        full_delay = 3;

        // illegal mode ignored
        do_start(2'b11);
        repeat (2) @(negedge clk);
        chk("illegal_mode_idle", int'(bus.state), S_IDLE);

        // async reset mid-spin
        do_start(2'b00);
        wait_state(S_SPIN, 200);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("async_reset_outputs", int'(outs()), 0);
        @(negedge clk); #2 reset = 1'b0;

        // randomized runs
        rand_en = 1'b1;
        for (int r = 0; r < 40; r++) begin
            if (bus.state == 4'd8) reset_pulse();
            full_delay  = $urandom_range(1, 21);
            empty_delay = $urandom_range(1, 21);
            do_start(2'($urandom_range(0, 3)));
            n = 0;
            while (bus.state != 4'd0 && bus.state != 4'd8 && n < 800) begin
                @(negedge clk); n++;
            end
            if (n >= 800) begin
                checks++; errors++;
                $display("FAIL random_run %0d timeout, state %0d", r, bus.state);
            end
        end
        rand_en = 1'b0;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
